// File: rtl/joystick_input.sv
// Joystick/button input conditioning: invert, 2-flop sync and per-input debounce,
// with a read-only register window, sticky clear-on-read press/release flags and an irq.
module joystick_input #(
  parameter int DEBOUNCE_CYCLES = 270000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       joystick_0,
  input  logic       joystick_1,
  input  logic       joystick_2,
  input  logic       joystick_3,
  input  logic       joystick_4,
  input  logic       button_select,
  input  logic       button_0,
  input  logic [1:0] address,
  input  logic       read_strobe,
  output logic [7:0] data_out,
  output logic       irq
);
  localparam int NUM_LANES = 7;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0] ID = 8'hA2;

  logic [NUM_LANES-1:0] raw, sync_a, sync_b, stable, toggle;
  logic [NUM_LANES-1:0] rise, fall, press, rel;
  logic                 clr_press, clr_rel;

  assign raw = ~{button_select, button_0, joystick_4, joystick_3,
                 joystick_2, joystick_1, joystick_0};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Per-lane debouncer: the counter only runs while sync_b disagrees with stable,
  // and the flip happens on the edge the count would reach DEBOUNCE_CYCLES.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [CW-1:0] cnt;
    assign toggle[i] = (sync_b[i] != stable[i]) && (cnt == LAST);
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt       <= '0;
        stable[i] <= 1'b0;
      end else if (sync_b[i] == stable[i]) begin
        cnt <= '0;
      end else if (toggle[i]) begin
        cnt       <= '0;
        stable[i] <= ~stable[i];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise      = toggle & ~stable;
  assign fall      = toggle & stable;
  assign clr_press = read_strobe && (address == 2'd1);
  assign clr_rel   = read_strobe && (address == 2'd2);

  // A new edge landing on a clearing read survives; data_out reflects pre-edge flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      press    <= '0;
      rel      <= '0;
      irq      <= 1'b0;
      data_out <= '0;
    end else begin
      press <= (clr_press ? '0 : press) | rise;
      rel   <= (clr_rel   ? '0 : rel)   | fall;
      irq   <= |press;
      if (read_strobe) begin
        case (address)
          2'd0:    data_out <= {1'b0, stable};
          2'd1:    data_out <= {1'b0, press};
          2'd2:    data_out <= {1'b0, rel};
          default: data_out <= ID;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_joystick_input.sv
// Directed bench for joystick_input with a cycle-level history model checked every cycle.
module tb_joystick_input;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       joystick_0 = 1'b1, joystick_1 = 1'b1, joystick_2 = 1'b1;
  logic       joystick_3 = 1'b1, joystick_4 = 1'b1;
  logic       button_select = 1'b1, button_0 = 1'b1;
  logic [1:0] address = 2'd0;
  logic       read_strobe = 1'b0;
  logic [7:0] data_out;
  logic       irq;

  int cmp_cnt = 0;
  int fail_cnt = 0;

  joystick_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset(reset),
    .joystick_0(joystick_0), .joystick_1(joystick_1), .joystick_2(joystick_2),
    .joystick_3(joystick_3), .joystick_4(joystick_4),
    .button_select(button_select), .button_0(button_0),
    .address(address), .read_strobe(read_strobe),
    .data_out(data_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an input flips once its view (raw pin seen two edges late) has disagreed
  // with the stable level for the last D edges, all of them after the previous flip/reset.
  logic [6:0] rawh   [0:4095];
  logic [6:0] sighth [0:4095];
  logic [6:0] m_stable, m_press, m_rel;
  logic [7:0] m_data;
  logic       m_irq;
  int         last_tog [7];
  int         last_rst;
  int         t;

  initial begin : model
    logic [6:0] sight;
    bit ok;
    t = 0; last_rst = 0;
    m_stable = '0; m_press = '0; m_rel = '0; m_data = '0; m_irq = 1'b0;
    for (int i = 0; i < 7; i++) last_tog[i] = 0;
    forever begin
      @(posedge clk); #1;
      rawh[t] = ~{button_select, button_0, joystick_4, joystick_3,
                  joystick_2, joystick_1, joystick_0};
      if (reset) begin
        m_stable = '0; m_press = '0; m_rel = '0; m_data = '0; m_irq = 1'b0;
        last_rst = t;
        for (int i = 0; i < 7; i++) last_tog[i] = t;
        sighth[t] = '0;
      end else begin
        sight = (t - 2 > last_rst) ? rawh[t-2] : 7'd0;
        sighth[t] = sight;
        if (read_strobe) begin
          case (address)
            2'd0: m_data = {1'b0, m_stable};
            2'd1: m_data = {1'b0, m_press};
            2'd2: m_data = {1'b0, m_rel};
            default: m_data = 8'hA2;
          endcase
        end
        m_irq = |m_press;
        if (read_strobe && address == 2'd1) m_press = '0;
        if (read_strobe && address == 2'd2) m_rel = '0;
        for (int i = 0; i < 7; i++) begin
          if (t - last_tog[i] >= D) begin
            ok = 1'b1;
            for (int k = 0; k < D; k++)
              if (sighth[t-k][i] == m_stable[i]) ok = 1'b0;
            if (ok) begin
              last_tog[i] = t;
              if (m_stable[i]) m_rel[i] = 1'b1;
              else             m_press[i] = 1'b1;
              m_stable[i] = ~m_stable[i];
            end
          end
        end
      end
      t++;
      chk("model_data_out", data_out, m_data);
      chk("model_irq", {7'd0, irq}, {7'd0, m_irq});
    end
  end

  task automatic do_read(input logic [1:0] a, input logic [7:0] exp, input string nm);
    read_strobe = 1'b1;
    address = a;
    @(negedge clk);
    read_strobe = 1'b0;
    chk(nm, data_out, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    wait_cyc(3);
    reset = 1'b0;
    chk("reset_data_out", data_out, 8'h00);
    chk("reset_irq", {7'd0, irq}, 8'h00);
    do_read(2'd0, 8'h00, "reset_addr0");
    do_read(2'd1, 8'h00, "reset_addr1");
    do_read(2'd2, 8'h00, "reset_addr2");
    do_read(2'd3, 8'hA2, "id_addr3");

    // joystick_2 press: stable flips at edge 5, irq at edge 6
    joystick_2 = 1'b0;
    wait_cyc(5);
    do_read(2'd0, 8'h00, "js2_not_yet_edge4");
    chk("js2_irq_edge5", {7'd0, irq}, 8'h00);
    do_read(2'd0, 8'h04, "js2_stable_edge5");
    chk("js2_irq_edge6", {7'd0, irq}, 8'h01);
    do_read(2'd1, 8'h04, "js2_press");
    chk("irq_hold_on_clear_edge", {7'd0, irq}, 8'h01);
    do_read(2'd1, 8'h00, "press_cleared");
    chk("irq_dropped", {7'd0, irq}, 8'h00);
    do_read(2'd2, 8'h00, "no_release_yet");

    // button_0 bounce: low 3, high 1, then low
    button_0 = 1'b0; wait_cyc(3);
    button_0 = 1'b1; wait_cyc(1);
    button_0 = 1'b0; wait_cyc(12);
    do_read(2'd1, 8'h20, "bounce_one_press");
    do_read(2'd2, 8'h00, "bounce_no_release");
    do_read(2'd0, 8'h24, "bounce_stable");

    // collision: clearing read lands on button_select's flip edge
    button_select = 1'b0;
    wait_cyc(5);
    do_read(2'd1, 8'h00, "collision_excluded");
    do_read(2'd1, 8'h40, "collision_kept");
    chk("collision_irq", {7'd0, irq}, 8'h01);

    // release joystick_2
    joystick_2 = 1'b1;
    wait_cyc(8);
    do_read(2'd2, 8'h04, "js2_release");

    // pending release on button_0, then reset mid-count on joystick_0
    button_0 = 1'b1;
    wait_cyc(8);
    joystick_0 = 1'b0;
    wait_cyc(3);
    reset = 1'b1; read_strobe = 1'b1; address = 2'd3;
    @(negedge clk);
    reset = 1'b0; read_strobe = 1'b0;
    chk("reset_beats_read", data_out, 8'h00);
    do_read(2'd2, 8'h00, "reset_clears_release");
    wait_cyc(4);
    do_read(2'd1, 8'h00, "post_reset_not_yet");
    do_read(2'd1, 8'h41, "post_reset_press");
    do_read(2'd0, 8'h41, "post_reset_stable");

    wait_cyc(2);
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end
endmodule
